imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Write-side companion of the instruction memory bank. Takes a byte stream from a host
//   link, packs four bytes into one 32-bit MIPS instruction and writes it to the IMem write
//   port at consecutive word-aligned byte addresses (0, 4, 8, ...).
//   Holds the CPU (cpu_hold) while a program image is loading.
// PARAMETERS
//   ADDR_W      8    width of the IMem byte address (memory indexes word = addr>>2)
//   DEPTH       64   IMem depth in words; num_words above DEPTH is clamped to DEPTH
//   BIG_ENDIAN  1    1: first byte -> bits[31:24]; 0: first byte -> bits[7:0]
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous, active-low reset
//   start       in   1       begin a load; sampled only in IDLE
//   abort       in   1       cancel the load in progress
//   num_words   in   7       number of 32-bit words to load (0..DEPTH)
//   byte_valid  in   1       host byte available
//   byte_data   in   8       host byte
//   byte_ready  out  1       loader accepts a byte this cycle
//   mem_we      out  1       IMem write strobe (one cycle per word)
//   mem_addr    out  ADDR_W  IMem byte address, always word-aligned (low 2 bits = 0)
//   mem_wdata   out  32      instruction word to write
//   busy        out  1       load in progress (state != IDLE)
//   cpu_hold    out  1       stall request to the core; equals busy
//   done        out  1       one-cycle pulse after the last word is written
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; byte_ready, mem_we, busy, cpu_hold, done = 0;
//     mem_addr=0, mem_wdata=0; byte counter=0, word index=0.
//   States: IDLE, LOAD, WRITE, DONE.
//   IDLE: byte_ready=0. start=1 and num_words!=0 -> LOAD, word index=0, byte count=0.
//     start=1 and num_words==0 -> DONE (done pulse, no writes).
//     num_words is latched at start; later changes are ignored until the next load.
//   LOAD: byte_ready=1. A byte is taken when byte_valid && byte_ready.
//     BIG_ENDIAN=1: word <= {word[23:0], byte_data}; BIG_ENDIAN=0: word <= {byte_data, word[31:8]}.
//     Byte count wraps 3->0. When the 4th byte is taken -> WRITE.
//   WRITE: exactly one cycle. mem_we=1, mem_addr = word_index<<2 (truncated to ADDR_W),
//     mem_wdata = packed word, byte_ready=0. Then word index +1.
//     If this was word num_words-1 -> DONE, else -> LOAD.
//   DONE: done=1 for one cycle, busy stays 1 in this cycle -> IDLE.
//   Latency: 4th byte accepted on edge N; mem_we high during cycle N+1; after the last word,
//     done high during cycle N+2; busy low from N+3.
//   byte_valid=0 in LOAD: wait with no timeout; the partial word is kept.
//   start while busy: ignored. byte_valid in IDLE/WRITE/DONE: not accepted (byte_ready=0).
//   abort (any non-IDLE state, has priority over all other events): -> IDLE on the next edge.
//     The partial word is discarded, no mem_we, no done. A write already issued stays written.
//   Simultaneous abort and 4th-byte accept: abort wins, no write.
//   Address wrap: with DEPTH=64 the last address is 252; mem_addr never exceeds (DEPTH-1)*4.
//   mem_addr/mem_wdata hold their last value outside WRITE; consumers qualify with mem_we.
// STRUCTURE
//   Shared package imem_pkg: state encoding (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, DONE=2'd3),
//     WORD_W=32, BYTES_PER_WORD=4; the IMem bank and the core's stall logic use the same package.
//   Sub-module byte_packer: 2-bit byte counter plus 32-bit shift register (endianness
//     parameter, clear input, word_full output). Top level holds the FSM, word index and
//     output registers.
// TESTING
//   1. Reset mid-load (rst_n low after 2 bytes) -> all outputs 0 at once; next load
//      starts cleanly at address 0.
//   2. start, num_words=1, bytes 8'hAD,8'h10,8'h00,8'h00 back-to-back -> one mem_we,
//      mem_addr=0, mem_wdata=32'hAD100000, done one cycle later, busy low after that.
//   3. num_words=3, byte_valid toggled every other cycle -> writes at 0,4,8 with the
//      correct words; byte_ready=0 during each WRITE cycle; exactly one done pulse.
//   4. start, num_words=0 -> done pulse on the next cycle, no mem_we.
//   5. abort together with the 4th byte of word 1 -> no write at addr 4, no done,
//      IDLE next cycle; word 0 was written earlier.
//   6. num_words=64 (DEPTH), BIG_ENDIAN=0 with bytes 00,00,08,20 -> word 32'h20080000
//      at addr 0; last write at addr 252, 64 mem_we pulses in total.

Source files
------------

// File: rtl/imem_pkg.sv
// +--------------------------------------------------------------------+
// | imem_pkg - shared IMem/loader/stall constants and state encoding   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package imem_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// +--------------------------------------------------------------------+
// | byte_packer - byte counter plus shift register forming 32-bit words|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module byte_packer
    import imem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              take,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word_next,
    output logic              word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;

    // word_next is the value the register takes on the accepting edge, so the
    // top can capture a completed word on the same edge as its last byte.
    generate
        if (BIG_ENDIAN) begin : g_big
            assign word_next = {r_word[WORD_W-9:0], byte_data};
        end else begin : g_little
            assign word_next = {byte_data, r_word[WORD_W-1:8]};
        end
    endgenerate

    assign word_full = take && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (take) begin
            r_cnt  <= r_cnt + 1'b1;
            r_word <= word_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +--------------------------------------------------------------------+
// | imem_loader - packs host bytes into words and writes them to IMem  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 64,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [6:0]        num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    state_t            r_state;
    state_t            w_state_next;
    logic [6:0]        r_num_words;
    logic [6:0]        r_word_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;

    logic              w_start_ok;
    logic              w_abort_ok;
    logic              w_take;
    logic              w_clear;
    logic              w_word_full;
    logic              w_last_word;
    logic [6:0]        w_nw_clamped;
    logic [WORD_W-1:0] w_word_next;

    assign w_start_ok   = (r_state == ST_IDLE) && start;
    assign w_abort_ok   = (r_state != ST_IDLE) && abort;
    assign w_take       = (r_state == ST_LOAD) && byte_valid;
    assign w_clear      = w_start_ok || w_abort_ok;
    assign w_last_word  = (r_word_idx == (r_num_words - 7'd1));
    assign w_nw_clamped = (num_words > 7'(DEPTH)) ? 7'(DEPTH) : num_words;

    byte_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .take      (w_take),
        .byte_data (byte_data),
        .word_next (w_word_next),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (num_words == 7'd0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (w_word_full) w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = w_last_word ? ST_DONE : ST_LOAD;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        // Abort overrides everything, including a word completing this cycle.
        if (w_abort_ok) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_words <= '0;
            r_word_idx  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_start_ok) begin
                r_num_words <= w_nw_clamped;
                r_word_idx  <= '0;
            end
            if (w_word_full && !w_abort_ok) begin
                r_mem_addr  <= ADDR_W'({r_word_idx, 2'b00});
                r_mem_wdata <= w_word_next;
            end
            if (r_state == ST_WRITE) begin
                r_word_idx <= r_word_idx + 7'd1;
            end
        end
    end

    assign byte_ready = (r_state == ST_LOAD);
    assign mem_we     = (r_state == ST_WRITE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = (r_state != ST_IDLE);
    assign cpu_hold   = busy;
    assign done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +--------------------------------------------------------------------+
// | tb_imem_loader - directed self-checking bench for imem_loader      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [6:0]  num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        be_byte_ready, be_mem_we, be_busy, be_cpu_hold, be_done;
    logic [7:0]  be_mem_addr;
    logic [31:0] be_mem_wdata;
    logic        le_byte_ready, le_mem_we, le_busy, le_cpu_hold, le_done;
    logic [7:0]  le_mem_addr;
    logic [31:0] le_mem_wdata;

    int total = 0;
    int bad   = 0;
    int be_we_cnt = 0, be_done_cnt = 0;
    int le_we_cnt = 0, le_done_cnt = 0;
    logic [7:0] le_last_addr = 8'hFF;

    imem_loader #(.ADDR_W(8), .DEPTH(64), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(be_byte_ready),
        .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
        .busy(be_busy), .cpu_hold(be_cpu_hold), .done(be_done)
    );

    imem_loader #(.ADDR_W(8), .DEPTH(64), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_byte_ready),
        .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
        .busy(le_busy), .cpu_hold(le_cpu_hold), .done(le_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (be_mem_we) be_we_cnt++;
        if (be_done)   be_done_cnt++;
        if (le_mem_we) begin
            le_we_cnt++;
            le_last_addr = le_mem_addr;
        end
        if (le_done)   le_done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] words [3];
        int we0, dn0;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_words = 7'd0;
        byte_valid = 1'b0; byte_data = 8'h00;
        step(); step();

        // Reset state
        chk("rst_busy",  {31'd0, be_busy},       32'd0);
        chk("rst_hold",  {31'd0, be_cpu_hold},   32'd0);
        chk("rst_ready", {31'd0, be_byte_ready}, 32'd0);
        chk("rst_we",    {31'd0, be_mem_we},     32'd0);
        chk("rst_done",  {31'd0, be_done},       32'd0);
        chk("rst_addr",  {24'd0, be_mem_addr},   32'd0);
        chk("rst_wdata", be_mem_wdata,           32'd0);
        rst_n = 1'b1;

        // Reset asserted mid-load after two bytes
        start = 1'b1; num_words = 7'd1; step();
        start = 1'b0;
        chk("t1_ready", {31'd0, be_byte_ready}, 32'd1);
        byte_valid = 1'b1; byte_data = 8'h5A; step();
        byte_data = 8'hC3; step();
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_busy",  {31'd0, be_busy},       32'd0);
        chk("t1_async_ready", {31'd0, be_byte_ready}, 32'd0);
        chk("t1_async_hold",  {31'd0, be_cpu_hold},   32'd0);
        step();
        rst_n = 1'b1;

        // Single word, back-to-back bytes
        we0 = be_we_cnt; dn0 = be_done_cnt;
        start = 1'b1; num_words = 7'd1; step();
        start = 1'b0; byte_valid = 1'b1;
        byte_data = 8'hAD; step();
        byte_data = 8'h10; step();
        byte_data = 8'h00; step();
        byte_data = 8'h00; step();
        byte_valid = 1'b0;
        chk("t2_we",    {31'd0, be_mem_we},     32'd1);
        chk("t2_addr",  {24'd0, be_mem_addr},   32'd0);
        chk("t2_wdata", be_mem_wdata,           32'hAD100000);
        chk("t2_ready", {31'd0, be_byte_ready}, 32'd0);
        step();
        chk("t2_done",      {31'd0, be_done},   32'd1);
        chk("t2_done_busy", {31'd0, be_busy},   32'd1);
        chk("t2_done_we",   {31'd0, be_mem_we}, 32'd0);
        step();
        chk("t2_idle_busy", {31'd0, be_busy},   32'd0);
        chk("t2_idle_done", {31'd0, be_done},   32'd0);
        chk("t2_we_count",   be_we_cnt - we0,   32'd1);
        chk("t2_done_count", be_done_cnt - dn0, 32'd1);

        // Three words, byte_valid toggled every other cycle
        words[0] = 32'h11223344; words[1] = 32'h55667788; words[2] = 32'h99AABBCC;
        we0 = be_we_cnt; dn0 = be_done_cnt;
        start = 1'b1; num_words = 7'd3; step();
        start = 1'b0; num_words = 7'd0;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                byte_valid = 1'b1;
                byte_data  = words[w][31-8*b -: 8];
                step();
                byte_valid = 1'b0;
                if (b == 3) begin
                    chk($sformatf("t3_we%0d", w),    {31'd0, be_mem_we},     32'd1);
                    chk($sformatf("t3_ready%0d", w), {31'd0, be_byte_ready}, 32'd0);
                    chk($sformatf("t3_addr%0d", w),  {24'd0, be_mem_addr},   32'(w * 4));
                    chk($sformatf("t3_wdata%0d", w), be_mem_wdata,           words[w]);
                end
                step();
            end
        end
        chk("t3_done", {31'd0, be_done}, 32'd1);
        step();
        chk("t3_idle",       {31'd0, be_busy},  32'd0);
        chk("t3_we_count",   be_we_cnt - we0,   32'd3);
        chk("t3_done_count", be_done_cnt - dn0, 32'd1);

        // Zero-length load
        we0 = be_we_cnt;
        start = 1'b1; num_words = 7'd0; step();
        start = 1'b0;
        chk("t4_done", {31'd0, be_done},   32'd1);
        chk("t4_busy", {31'd0, be_busy},   32'd1);
        chk("t4_we",   {31'd0, be_mem_we}, 32'd0);
        step();
        chk("t4_idle",     {31'd0, be_busy}, 32'd0);
        chk("t4_we_count", be_we_cnt - we0,  32'd0);

        // Abort coinciding with the 4th byte of word 1
        we0 = be_we_cnt; dn0 = be_done_cnt;
        start = 1'b1; num_words = 7'd2; step();
        start = 1'b0; byte_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            byte_data = 8'(b + 1); step();
        end
        chk("t5_w0_we",    {31'd0, be_mem_we}, 32'd1);
        chk("t5_w0_wdata", be_mem_wdata,       32'h01020304);
        step();
        for (int b = 0; b < 3; b++) begin
            byte_data = 8'hE0 + 8'(b); step();
        end
        byte_data = 8'hEF; abort = 1'b1; step();
        abort = 1'b0; byte_valid = 1'b0;
        chk("t5_abort_busy", {31'd0, be_busy},   32'd0);
        chk("t5_abort_we",   {31'd0, be_mem_we}, 32'd0);
        chk("t5_abort_done", {31'd0, be_done},   32'd0);
        chk("t5_abort_addr", {24'd0, be_mem_addr}, 32'd0);
        step();
        chk("t5_we_count",   be_we_cnt - we0,   32'd1);
        chk("t5_done_count", be_done_cnt - dn0, 32'd0);

        // Full-depth load on the little-endian instance
        we0 = le_we_cnt; dn0 = le_done_cnt;
        start = 1'b1; num_words = 7'd64; step();
        start = 1'b0; byte_valid = 1'b1;
        for (int w = 0; w < 64; w++) begin
            if (w == 0) begin
                byte_data = 8'h00; step();
                byte_data = 8'h00; step();
                byte_data = 8'h08; step();
                byte_data = 8'h20; step();
                chk("t6_w0_addr",  {24'd0, le_mem_addr}, 32'd0);
                chk("t6_w0_wdata", le_mem_wdata,         32'h20080000);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    byte_data = 8'(w); step();
                end
            end
            step();
        end
        byte_valid = 1'b0;
        chk("t6_done",       {31'd0, le_done},   32'd1);
        chk("t6_last_addr",  {24'd0, le_last_addr}, 32'd252);
        chk("t6_last_wdata", le_mem_wdata,       32'h3F3F3F3F);
        step();
        chk("t6_idle",       {31'd0, le_busy},   32'd0);
        chk("t6_we_count",   le_we_cnt - we0,    32'd64);
        chk("t6_done_count", le_done_cnt - dn0,  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
